// File: rtl/decode_pkg.sv
// decode_pkg: opcode map, write-back select codes, control-word layout and link registers.
// DECODE_ILLEGAL_TRAP_EN adds the illegal bit at the top of the control word.
package decode_pkg;
  localparam int OP_W = 5;
  localparam logic [OP_W-1:0] OP_ALU  = 5'b00000;
  localparam logic [OP_W-1:0] OP_J    = 5'b00001;
  localparam logic [OP_W-1:0] OP_BNE  = 5'b00010;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b00011;
  localparam logic [OP_W-1:0] OP_JR   = 5'b00100;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OP_W-1:0] OP_BLT  = 5'b00110;
  localparam logic [OP_W-1:0] OP_SW   = 5'b00111;
  localparam logic [OP_W-1:0] OP_LW   = 5'b01000;
  localparam logic [OP_W-1:0] OP_SETX = 5'b10101;
  localparam logic [OP_W-1:0] OP_BEX  = 5'b10110;
  localparam logic [1:0] RWD_ALU = 2'b00;
  localparam logic [1:0] RWD_MEM = 2'b01;
  localparam logic [1:0] RWD_PC1 = 2'b10;
  localparam logic [1:0] RWD_TGT = 2'b11;
  localparam logic [4:0] LINK_JAL  = 5'd31;
  localparam logic [4:0] LINK_SETX = 5'd30;
  typedef struct packed {
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
    logic       setx;
    logic       bex;
    logic       jr;
    logic       jal;
    logic       jp;
    logic       br_lt;
    logic       br_ne;
    logic       aluinb;
    logic [1:0] rwd;
    logic       rwe;
    logic       dmwe;
  } ctrl_t;
  localparam int CTRL_W       = $bits(ctrl_t);
  localparam int CTRL_DMWE    = 0;
  localparam int CTRL_RWE     = 1;
  localparam int CTRL_RWD     = 2;
  localparam int CTRL_ALUINB  = 4;
  localparam int CTRL_BR_NE   = 5;
  localparam int CTRL_BR_LT   = 6;
  localparam int CTRL_JP      = 7;
  localparam int CTRL_JAL     = 8;
  localparam int CTRL_JR      = 9;
  localparam int CTRL_BEX     = 10;
  localparam int CTRL_SETX    = 11;
  localparam int CTRL_ILLEGAL = 12;
endpackage

// File: rtl/decode_ctrl_rom.sv
// decode_ctrl_rom: combinational opcode -> control word and source-register usage flags.
// Unmapped opcodes decode to all-zero control (illegal bit set under DECODE_ILLEGAL_TRAP_EN).
module decode_ctrl_rom
  import decode_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl,
  output logic            use_rs,
  output logic            use_rd,
  output logic            use_rt,
  output logic            is_alu,
  output logic            is_lw
);
  logic alu, j, bne, jal, jr, addi, blt, sw, lw, setx, bex;
  assign alu  = opcode == OP_ALU;
  assign j    = opcode == OP_J;
  assign bne  = opcode == OP_BNE;
  assign jal  = opcode == OP_JAL;
  assign jr   = opcode == OP_JR;
  assign addi = opcode == OP_ADDI;
  assign blt  = opcode == OP_BLT;
  assign sw   = opcode == OP_SW;
  assign lw   = opcode == OP_LW;
  assign setx = opcode == OP_SETX;
  assign bex  = opcode == OP_BEX;
  always_comb begin
    ctrl = '0;
    ctrl.dmwe   = sw;
    ctrl.rwe    = alu | addi | lw | jal | setx;
    ctrl.rwd    = lw ? RWD_MEM : jal ? RWD_PC1 : setx ? RWD_TGT : RWD_ALU;
    ctrl.aluinb = addi | sw | lw;
    ctrl.br_ne  = bne;
    ctrl.br_lt  = blt;
    ctrl.jp     = j | jal;
    ctrl.jal    = jal;
    ctrl.jr     = jr;
    ctrl.bex    = bex;
    ctrl.setx   = setx;
`ifdef DECODE_ILLEGAL_TRAP_EN
    ctrl.illegal = ~(alu | j | bne | jal | jr | addi | blt | sw | lw | setx | bex);
`endif
  end
  // sw/bne/blt/jr read the rd field as a source operand
  assign use_rs = alu | addi | sw | lw | bne | blt;
  assign use_rd = sw | bne | blt | jr;
  assign use_rt = alu;
  assign is_alu = alu;
  assign is_lw  = lw;
endmodule

// File: rtl/pipelined_decode_stage.sv
// pipelined_decode_stage: registered valid/ready decode stage with load-use bubbles and flush.
// DECODE_ILLEGAL_TRAP_EN adds the illegal control bit and the saturating illegal_cnt port.
module pipelined_decode_stage
  import decode_pkg::*;
#(
  parameter int INSN_W          = 32,
  parameter int OPCODE_W        = 5,
  parameter int REG_W           = 5,
  parameter int PC_W            = 12,
  parameter int LOADUSE_BUBBLES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_insn,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [REG_W-1:0]  out_rd,
  output logic [REG_W-1:0]  out_rs,
  output logic [REG_W-1:0]  out_rt,
  output logic [31:0]       out_imm,
  output logic [26:0]       out_target,
  output logic [4:0]        out_aluop,
  output logic [4:0]        out_shamt,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic [7:0]        illegal_cnt
`endif
);
  localparam int RD_LSB = INSN_W - OPCODE_W - REG_W;
  localparam int RS_LSB = RD_LSB - REG_W;
  localparam int RT_LSB = RS_LSB - REG_W;
  localparam int BW     = LOADUSE_BUBBLES > 1 ? $clog2(LOADUSE_BUBBLES) : 1;
  logic [REG_W-1:0] f_rd, f_rs, f_rt, rd_fin;
  ctrl_t            dec_ctrl;
  logic             use_rs, use_rd, use_rt, dec_alu, dec_lw;
  logic             stall, reads, hazard, xfer;
  logic             valid_d, valid_q, lw_d, lw_q;
  logic [BW-1:0]    bcnt_d, bcnt_q;
  logic [PC_W-1:0]  pc_d, pc_q;
  logic [REG_W-1:0] rd_d, rd_q, rs_d, rs_q, rt_d, rt_q;
  logic [31:0]      imm_d, imm_q;
  logic [26:0]      target_d, target_q;
  logic [4:0]       aluop_d, aluop_q, shamt_d, shamt_q;
  ctrl_t            ctrl_d, ctrl_q;
  assign f_rd = in_insn[RD_LSB +: REG_W];
  assign f_rs = in_insn[RS_LSB +: REG_W];
  assign f_rt = in_insn[RT_LSB +: REG_W];
  decode_ctrl_rom u_rom (
    .opcode (in_insn[INSN_W-1 -: OPCODE_W]),
    .ctrl   (dec_ctrl),
    .use_rs (use_rs),
    .use_rd (use_rd),
    .use_rt (use_rt),
    .is_alu (dec_alu),
    .is_lw  (dec_lw)
  );
  always_comb begin
    rd_fin   = dec_ctrl.jal ? LINK_JAL : dec_ctrl.setx ? LINK_SETX : f_rd;
    ctrl_d   = ctrl_q;
    stall    = bcnt_q != '0;
    reads    = (use_rs & (f_rs == rd_q)) | (use_rd & (f_rd == rd_q)) | (use_rt & (f_rt == rd_q));
    // a load leaving while a dependent insn waits drains the stage for the bubble count
    hazard   = (LOADUSE_BUBBLES != 0) & valid_q & lw_q & (rd_q != '0) & in_valid & reads & out_ready;
    in_ready = (~valid_q | out_ready) & ~stall & ~flush & ~hazard;
    xfer     = in_valid & in_ready;
    valid_d  = flush ? 1'b0 : xfer ? 1'b1 : out_ready ? 1'b0 : valid_q;
    bcnt_d   = flush ? '0 : hazard ? BW'(LOADUSE_BUBBLES - 1) : stall ? bcnt_q - BW'(1) : bcnt_q;
    lw_d     = xfer ? dec_lw : lw_q;
    pc_d     = xfer ? in_pc : pc_q;
    rd_d     = xfer ? rd_fin : rd_q;
    rs_d     = xfer ? f_rs : rs_q;
    rt_d     = xfer ? f_rt : rt_q;
    imm_d    = xfer ? {{15{in_insn[16]}}, in_insn[16:0]} : imm_q;
    target_d = xfer ? in_insn[26:0] : target_q;
    aluop_d  = xfer ? (dec_alu ? in_insn[6:2] : 5'd0) : aluop_q;
    shamt_d  = xfer ? in_insn[11:7] : shamt_q;
    if (xfer) begin
      ctrl_d     = dec_ctrl;
      ctrl_d.rwe = dec_ctrl.rwe & (rd_fin != '0);
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      bcnt_q   <= '0;
      lw_q     <= 1'b0;
      pc_q     <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      imm_q    <= '0;
      target_q <= '0;
      aluop_q  <= '0;
      shamt_q  <= '0;
      ctrl_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      bcnt_q   <= bcnt_d;
      lw_q     <= lw_d;
      pc_q     <= pc_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      imm_q    <= imm_d;
      target_q <= target_d;
      aluop_q  <= aluop_d;
      shamt_q  <= shamt_d;
      ctrl_q   <= ctrl_d;
    end
  end
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic [7:0] illegal_cnt_d, illegal_cnt_q;
  always_comb begin
    illegal_cnt_d = (xfer & dec_ctrl.illegal & (illegal_cnt_q != 8'hFF)) ? illegal_cnt_q + 8'd1 : illegal_cnt_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) illegal_cnt_q <= '0;
    else illegal_cnt_q <= illegal_cnt_d;
  end
  assign illegal_cnt = illegal_cnt_q;
`endif
  assign out_valid  = valid_q;
  assign out_pc     = pc_q;
  assign out_rd     = rd_q;
  assign out_rs     = rs_q;
  assign out_rt     = rt_q;
  assign out_imm    = imm_q;
  assign out_target = target_q;
  assign out_aluop  = aluop_q;
  assign out_shamt  = shamt_q;
  assign out_ctrl   = ctrl_q;
endmodule

// File: tb/tb_pipelined_decode_stage.sv
// tb_pipelined_decode_stage: directed checks of decode, handshake, load-use bubble, flush and reset.
// Define DECODE_ILLEGAL_TRAP_EN for both bench and RTL to cover the illegal counter.
module tb_pipelined_decode_stage;
  import decode_pkg::*;
  logic        clock = 1'b0;
  logic        reset_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_insn, out_imm;
  logic [11:0] in_pc, out_pc;
  logic [4:0]  out_rd, out_rs, out_rt, out_aluop, out_shamt;
  logic [26:0] out_target;
  logic [CTRL_W-1:0] out_ctrl;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic [7:0]  illegal_cnt;
`endif
  int passed = 0;
  int total  = 0;

  pipelined_decode_stage dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_rs(out_rs),
    .out_rt(out_rt), .out_imm(out_imm), .out_target(out_target), .out_aluop(out_aluop),
    .out_shamt(out_shamt), .out_ctrl(out_ctrl)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .illegal_cnt(illegal_cnt)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [16:0] low);
    return {op, rd, rs, low};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset_n = 0; in_valid = 0; in_insn = 0; in_pc = 0; flush = 0; out_ready = 1;
    repeat (2) @(negedge clock);
    chk("rst_valid", out_valid, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_imm", out_imm, 0);
    reset_n = 1;
    #1 chk("rst_ready", in_ready, 1);
    // addi r1,r2,-5
    @(negedge clock); in_valid = 1; in_insn = mk(OP_ADDI, 1, 2, 17'h1FFFB); in_pc = 12'h010;
    #1 chk("addi_ready", in_ready, 1);
    @(negedge clock); in_valid = 0;
    chk("addi_valid", out_valid, 1);
    chk("addi_ctrl", out_ctrl, 32'h012);
    chk("addi_imm", out_imm, 32'hFFFFFFFB);
    chk("addi_rd", out_rd, 1);
    chk("addi_rs", out_rs, 2);
    chk("addi_pc", out_pc, 12'h010);
    chk("addi_aluop", out_aluop, 0);
    @(negedge clock);
    chk("drain_valid", out_valid, 0);
    // lw r3 then add r4,r3,r5
    in_valid = 1; in_insn = mk(OP_LW, 3, 1, 17'd4);
    @(negedge clock);
    chk("lw_valid", out_valid, 1);
    chk("lw_ctrl", out_ctrl, 32'h016);
    in_insn = mk(OP_ALU, 4, 3, {5'd5, 5'd0, 5'd1, 2'b00});
    #1 chk("lu_ready", in_ready, 0);
    @(negedge clock);
    chk("lu_bubble", out_valid, 0);
    #1 chk("lu_ready_back", in_ready, 1);
    @(negedge clock);
    chk("add_valid", out_valid, 1);
    chk("add_rd", out_rd, 4);
    chk("add_rs", out_rs, 3);
    chk("add_rt", out_rt, 5);
    chk("add_aluop", out_aluop, 1);
    chk("add_ctrl", out_ctrl, 32'h002);
    // lw r3 then an independent addi: no bubble
    in_insn = mk(OP_LW, 3, 1, 17'd4);
    @(negedge clock);
    in_insn = mk(OP_ADDI, 5, 4, 17'd1);
    #1 chk("indep_ready", in_ready, 1);
    @(negedge clock);
    chk("indep_rd", out_rd, 5);
    chk("indep_valid", out_valid, 1);
    // lw r3 then sw r3 (rd field used as source)
    in_insn = mk(OP_LW, 3, 1, 17'd4);
    @(negedge clock);
    in_insn = mk(OP_SW, 3, 0, 17'd0);
    #1 chk("lu_sw_ready", in_ready, 0);
    @(negedge clock);
    chk("lu_sw_bubble", out_valid, 0);
    @(negedge clock);
    chk("sw_valid", out_valid, 1);
    chk("sw_ctrl", out_ctrl, 32'h011);
    // jal then addi r0 back-to-back
    in_insn = {OP_JAL, 27'h100};
    @(negedge clock);
    chk("jal_rd", out_rd, 31);
    chk("jal_ctrl", out_ctrl, 32'h18A);
    chk("jal_target", out_target, 27'h100);
    in_insn = mk(OP_ADDI, 0, 1, 17'd3);
    #1 chk("jal_next_ready", in_ready, 1);
    @(negedge clock);
    chk("addi_r0_ctrl", out_ctrl, 32'h010);
    chk("addi_r0_rd", out_rd, 0);
    // setx
    in_insn = {OP_SETX, 27'h5};
    @(negedge clock);
    chk("setx_rd", out_rd, 30);
    chk("setx_ctrl", out_ctrl, 32'h80E);
    // backpressure for 3 cycles
    in_insn = mk(OP_ADDI, 7, 0, 17'd9);
    @(negedge clock);
    chk("bp_rd0", out_rd, 7);
    out_ready = 0; in_insn = mk(OP_ADDI, 8, 0, 17'd10);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", in_ready, 0);
      @(negedge clock);
      chk("bp_valid", out_valid, 1);
      chk("bp_rd", out_rd, 7);
      chk("bp_imm", out_imm, 9);
    end
    out_ready = 1;
    #1 chk("bp_release_ready", in_ready, 1);
    @(negedge clock);
    chk("bp_next_rd", out_rd, 8);
    chk("bp_next_imm", out_imm, 10);
    // flush coincident with sw
    in_insn = mk(OP_SW, 9, 1, 17'd0); flush = 1;
    #1 chk("flush_ready", in_ready, 0);
    @(negedge clock); flush = 0; in_valid = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_dmwe", out_ctrl[CTRL_DMWE], 0);
    chk("flush_rd", out_rd, 8);
    // illegal opcode 11111
    in_valid = 1; in_insn = 32'hFFFFFFFF;
    @(negedge clock);
    chk("ill_valid", out_valid, 1);
    chk("ill_ctrl", out_ctrl[11:0], 0);
    chk("ill_aluop", out_aluop, 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("ill_bit", out_ctrl[CTRL_ILLEGAL], 1);
    chk("ill_cnt1", illegal_cnt, 1);
    repeat (299) @(negedge clock);
    chk("ill_cnt_sat", illegal_cnt, 255);
`endif
    in_valid = 0;
    @(negedge clock);
    // asynchronous reset while holding a valid word
    in_valid = 1; in_insn = mk(OP_ADDI, 7, 0, 17'd9); out_ready = 0;
    @(negedge clock);
    chk("pre_rst_valid", out_valid, 1);
    #2 reset_n = 0;
    #1 chk("async_rst_valid", out_valid, 0);
    chk("async_rst_rd", out_rd, 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("async_rst_cnt", illegal_cnt, 0);
`endif
    in_valid = 0;
    @(negedge clock); reset_n = 1; out_ready = 1;
    #1 chk("post_rst_ready", in_ready, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipelined_decode_stage.md
Name: pipelined_decode_stage

Overview:
- Registered, handshaked decode stage for the 5-bit-opcode processor.
- Sits between fetch (F/D latch) and execute.
- Decodes the full opcode map into a control word and extracts operand fields.
- Detects load-use hazards against the instruction it currently holds, inserts a programmable number of bubbles, and honours a branch/jump flush.

Parameters:
- INSN_W, 32, instruction width.
- OPCODE_W, 5, opcode field width, bits [INSN_W-1 -: OPCODE_W].
- REG_W, 5, register-address width.
- PC_W, 12, program-counter width.
- LOADUSE_BUBBLES, 1, bubbles inserted on a load-use hazard (0 disables detection).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage accepts this cycle.
- in_insn  in  INSN_W  instruction word.
- in_pc  in  PC_W  instruction PC.
- flush  in  1  synchronous kill of held and incoming instruction.
- out_valid  out  1  decoded word valid.
- out_ready  in  1  execute consumes.
- out_pc  out  PC_W  registered PC.
- out_rd/out_rs/out_rt  out  REG_W each  register fields; out_rd after override.
- out_imm  out  32  sign-extended insn[16:0].
- out_target  out  27  insn[26:0].
- out_aluop  out  5  insn[6:2], forced 00000 for non-ALU ops.
- out_shamt  out  5  insn[11:7].
- out_ctrl  out  CTRL_W  control word, fields listed below.

Behaviour:
- Opcode map:
  - 00000 alu; 00001 j; 00010 bne; 00011 jal; 00100 jr; 00101 addi.
  - 00110 blt; 00111 sw; 01000 lw; 10101 setx; 10110 bex.
  - Anything else is illegal and decodes as a NOP (all ctrl 0).
- Control word fields:
  - dmwe = sw.
  - rwe = alu|addi|lw|jal|setx.
  - rwd[1:0]: 00 ALU, 01 mem (lw), 10 PC+1 (jal), 11 target (setx).
  - aluinb = addi|sw|lw.
  - br_ne, br_lt, jp (j|jal), jal, jr, bex, setx.
- rd override: jal sets out_rd = 31; setx sets out_rd = 30. rwe is forced 0 when the final rd = 0.
- Source usage:
  - rs is read by alu, addi, sw, lw, bne, blt.
  - The rd field is read as a source by sw, bne, blt, jr.
  - rt is read by alu only.
- Handshake:
  - Transfer occurs when in_valid & in_ready.
  - in_ready = (~out_valid | out_ready) & ~stall & ~flush.
  - Output register loads on transfer.
  - out_valid clears when out_ready is high with no transfer.
  - Output fields hold while out_valid & ~out_ready.
- Hazard:
  - Condition: held instruction is lw & out_valid & rd≠0, and the incoming instruction reads that register.
  - When the condition holds and out_ready is high, in_ready = 0, out_valid drops, and bubble counter bcnt = LOADUSE_BUBBLES-1.
  - stall = (bcnt≠0) decrements once per cycle.
  - Latency to the first accept after the load leaves: LOADUSE_BUBBLES cycles.
- Flush: next cycle out_valid = 0 and bcnt = 0. Flush wins over a simultaneous transfer or hazard.
- Latency: 1 cycle from transfer to out_valid. Throughput 1/cycle with no hazard.
- Reset: out_valid = 0, bcnt = 0, all data/ctrl outputs 0, in_ready = 1 after release.
- Reset asserted mid-stall clears everything immediately.

Optional Feature:
- DECODE_ILLEGAL_TRAP_EN defined:
  - out_ctrl gains an illegal bit, set for unmapped opcodes.
  - A sticky 8-bit saturating counter illegal_cnt (output port) counts accepted illegal instructions; it clears only on reset.
- Undefined: no illegal bit, no counter port; illegal opcodes are silent NOPs.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams;
  - rwd encodings;
  - the control-word struct/field offsets and CTRL_W;
  - link registers 31/30.
- Sub-module decode_ctrl_rom is purely combinational: opcode → control word plus source-use flags. The stage instantiates it once.

Test Plan:
- Reset then addi r1,r2,-5 (imm 0x1FFFB), out_ready = 1 → next cycle:
  - out_valid = 1;
  - aluinb = 1, rwe = 1, rwd = 00;
  - out_imm = 0xFFFFFFFB.
- lw r3 then add r4,r3,r5 back-to-back, LOADUSE_BUBBLES = 1:
  - exactly one out_valid = 0 cycle between them;
  - in_ready low for 1 cycle.
- jal target 0x100 → out_rd = 31, rwd = 10, jp = 1, jal = 1. addi r0,r1,3 → rwe = 0.
- out_ready held 0 for 3 cycles with in_valid = 1 → outputs stable and in_ready = 0; release → next instruction accepted the same cycle.
- flush asserted coincident with transfer of sw → next cycle out_valid = 0 and no dmwe observed.
- Opcode 11111, with and without DECODE_ILLEGAL_TRAP_EN:
  - ctrl all 0 in both builds;
  - with the macro, illegal = 1 and illegal_cnt increments, saturating at 255 after 300 issues.
